// File: rtl/cpu_async_rx.sv
// cpu_async_rx: four-phase send/ack serial responder assembling WIDTH-bit words onto a valid/ready port
module cpu_async_rx #(
  parameter int WIDTH       = 8,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic             data,
  output logic             ack,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK   = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  logic [1:0] state;
  logic send_m, send_s, data_m, data_s;
  logic [CW-1:0] count;
  logic [GW-1:0] gap;
  logic [WIDTH-1:0] sr;
  assign ack        = state == ACK;
  assign word_valid = state == VALID;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      send_m    <= 1'b0;
      send_s    <= 1'b0;
      data_m    <= 1'b0;
      data_s    <= 1'b0;
      count     <= '0;
      gap       <= '0;
      sr        <= '0;
      word      <= '0;
      frame_err <= 1'b0;
    end else begin
      send_m    <= send;
      send_s    <= send_m;
      data_m    <= data;
      data_s    <= data_m;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (send_s) begin
            sr    <= sr | (WIDTH'(data_s) << count);
            count <= count + 1'b1;
            gap   <= '0;
            state <= ACK;
          end else if (count != '0) begin
            // a stalled partial word is dropped so the next word starts clean
            if (gap == GW'(GAP_TIMEOUT - 1)) begin
              count     <= '0;
              sr        <= '0;
              gap       <= '0;
              frame_err <= 1'b1;
            end else gap <= gap + 1'b1;
          end
        ACK:
          if (!send_s) begin
            state <= count == CW'(WIDTH) ? VALID : IDLE;
            word  <= count == CW'(WIDTH) ? sr : word;
          end
        VALID:
          if (word_ready) begin
            count <= '0;
            sr    <= '0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_async_rx.sv
// tb_cpu_async_rx: randomized initiator plus directed scenarios, scoreboarded word and frame_err checks
module tb_cpu_async_rx;
  localparam int WIDTH = 8;
  localparam int GAP   = 64;
  logic clk = 0, rst = 1, send = 0, data = 0, word_ready = 0;
  logic ack, word_valid, frame_err;
  logic [WIDTH-1:0] word;
  int vectors = 0, miscompares = 0;
  int fe_seen = 0, fe_exp = 0;
  bit rnd_rdy = 0, prev_fe = 0, last_b = 0;
  int cur_n = 0;
  logic [WIDTH-1:0] cur_v = '0;
  logic [WIDTH-1:0] exp_q[$];

  cpu_async_rx #(.WIDTH(WIDTH), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .rst(rst), .send(send), .data(data), .ack(ack), .word(word),
    .word_valid(word_valid), .word_ready(word_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops expected words on each accept, audits frame_err pulses
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", word, 32'hdead);
      else chk("word", word, exp_q.pop_front());
    end
    if (frame_err) begin
      fe_seen++;
      chk("frame_err_width", prev_fe, 0);
    end
    prev_fe = frame_err;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_rdy) word_ready = $urandom_range(0, 1);
  end

  task automatic up(input bit b, input bit lat);
    int n;
    @(negedge clk);
    data = b; send = 1; last_b = b; n = 0;
    while (!ack && n < 3000) begin @(posedge clk); #1; n++; end
    if (lat) chk("ack_rise_lat", n, 3);
    chk("ack_rise", ack, 1);
  endtask

  task automatic down(input bit lat);
    int n;
    @(negedge clk);
    send = 0; n = 0;
    while (ack && n < 100) begin @(posedge clk); #1; n++; end
    if (lat) chk("ack_fall_lat", n, 3);
    chk("ack_fall", ack, 0);
    cur_v |= WIDTH'(last_b) << cur_n;
    cur_n++;
    if (cur_n == WIDTH) begin exp_q.push_back(cur_v); cur_n = 0; cur_v = '0; end
  endtask

  task automatic hs(input bit b, input bit lat);
    up(b, lat);
    down(lat);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
    if (k >= GAP + 10 && cur_n > 0) begin fe_exp++; cur_n = 0; cur_v = '0; end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) hs(v[i], 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((word_valid || exp_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_ack", ack, 0);
    chk("idle_valid", word_valid, 0);
    chk("idle_word", word, 0);
    chk("idle_ferr", fe_seen, 0);

    word_ready = 1;
    hs(1, 1);
    chk("one_bit_valid", word_valid, 0);
    for (int i = 1; i < WIDTH - 1; i++) hs(8'h4D >> i, 1);
    up(0, 1);
    down(1);
    chk("valid_rise", word_valid, 1);
    chk("word_4d", word, 8'h4D);
    @(posedge clk); #1;
    chk("valid_clear", word_valid, 0);
    wait_drain();

    word_ready = 0;
    send_word(8'h4D);
    @(negedge clk);
    chk("bp_valid", word_valid, 1);
    data = 1; send = 1; last_b = 1;
    repeat (30) @(negedge clk);
    chk("bp_ack_held", ack, 0);
    chk("bp_word_held", word, 8'h4D);
    word_ready = 1;
    begin
      int n = 0;
      while (!ack && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_ack_within3", n <= 3, 1);
    end
    chk("bp_valid_drop", word_valid, 0);
    down(1);
    for (int i = 1; i < WIDTH; i++) hs($urandom_range(0, 1), 1);
    wait_drain();

    for (int i = 0; i < 3; i++) hs($urandom_range(0, 1), 1);
    idle(GAP + 10);
    chk("gap_ferr", fe_seen, fe_exp);
    send_word(8'hA5);
    wait_drain();

    for (int i = 0; i < 4; i++) hs($urandom_range(0, 1), 1);
    up(1, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_ack", ack, 0);
    @(negedge clk);
    send = 0; cur_n = 0; cur_v = '0;
    @(negedge clk);
    rst = 0;
    send_word(8'h3C);
    wait_drain();
    chk("midrst_ferr", fe_seen, fe_exp);

    rnd_rdy = 1;
    for (int i = 0; i < 200; i++) begin
      hs($urandom_range(0, 1), 0);
      idle($urandom_range(0, 9) == 0 ? $urandom_range(GAP + 10, GAP + 30) : $urandom_range(0, GAP - 10));
    end
    rnd_rdy = 0;
    word_ready = 1;
    idle(GAP + 10);
    wait_drain();
    chk("ferr_total", fe_seen, fe_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_async_rx.md
Name: cpu_async_rx

Overview:
- Responder end of the CPU four-phase send/ack serial handshake.
- Each `send` assertion carries one `data` bit. The block synchronises `send`/`data`, captures the bit, and answers with `ack`.
- Bits are assembled into a WIDTH-bit word and presented on a valid/ready interface to the local consumer.
- Sits on the peripheral side, opposite the CPU-side initiator FSM.

Parameters:
- WIDTH, 8, bits per assembled word (2..32).
- GAP_TIMEOUT, 64, idle cycles allowed between bits of a partial word before the partial word is discarded (>=4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- send  input  1  request from initiator, asynchronous to clk; high = bit valid on data.
- data  input  1  serial data bit, stable while send high, asynchronous.
- ack  output  1  acknowledge to initiator, registered.
- word  output  WIDTH  assembled word, registered; holds value while word_valid.
- word_valid  output  1  word available to consumer.
- word_ready  input  1  consumer accepts word when word_valid & word_ready.
- frame_err  output  1  one-cycle pulse: partial word discarded on gap timeout.

Behaviour:
- Reset is synchronous, active-high; clk single clock.
- Reset values: ack=0, word=0, word_valid=0, frame_err=0, bit count=0, gap counter=0, shift register=0, both synchroniser stages=0, state=IDLE.
- Synchronisers:
  - send and data each pass through two flops: send_s, data_s.
  - FSM uses only send_s/data_s.
- IDLE (ack=0):
  - If send_s=1, capture data_s into shift register bit position [count], count+1, go to ACK.
  - ack rises on the 3rd rising edge after send rises: 2 sync + 1 state.
- ACK (ack=1):
  - Hold until send_s=0.
  - Then ack=0. If count==WIDTH: copy shift register to word, set word_valid=1, go to VALID. Otherwise go to IDLE.
  - ack falls 3 edges after send falls.
- VALID (ack=0, word_valid=1):
  - word is stable.
  - On word_valid & word_ready: word_valid=0 next cycle, count=0, shift register=0, go to IDLE.
  - A send_s=1 seen in VALID is not acknowledged (back-pressure); it is serviced in IDLE after acceptance.
  - word_ready while word_valid=0 is ignored.
- Bit order: first received bit lands in word[0], last bit in word[WIDTH-1].
- Gap timeout:
  - In IDLE with 0<count<WIDTH, the gap counter increments each cycle send_s=0; it clears on any capture.
  - When the gap counter reaches GAP_TIMEOUT: count=0, shift register=0, frame_err=1 for exactly one cycle, stay in IDLE.
  - Counter is inactive when count=0, in ACK, and in VALID.
- Simultaneous events:
  - Timeout and send_s=1 on the same cycle: capture wins, no frame_err.
  - word_ready in the same cycle word_valid rises: accepted next cycle (word_valid high at least 1 cycle).
- Reset mid-operation: any state returns to IDLE with ack=0 on the next edge; the partial word is lost; no frame_err.
- Unused state encoding → IDLE with ack=0.
- Throughput:
  - Minimum 6 clk cycles per bit handshake given an instant initiator.
  - Word-to-word gap is at least 1 cycle in VALID.

Test Plan:
- Reset → ack=0, word_valid=0, word=0, frame_err=0. Release reset, hold send=0 for 20 cycles → all outputs unchanged.
- Single bit, WIDTH=8, send=1 data=1 → ack=1 on 3rd edge. Drop send → ack=0 on 3rd edge after. word_valid stays 0, count=1.
- 8 handshakes, bits LSB-first 1,0,1,1,0,0,1,0, word_ready=1 → word=8'h4D, word_valid high 1 cycle after final ack fall, then cleared.
- Back-pressure:
  - word_ready=0 after full word, then a 9th send=1 for 30 cycles → ack stays 0, word stays 8'h4D.
  - Raise word_ready → word_valid drops; ack rises within 3 cycles; new bit captured into word[0].
- Gap timeout: send 3 bits, then send=0 for GAP_TIMEOUT cycles → frame_err pulses 1 cycle. Next 8 bits 8'hA5 → word=8'hA5 (no residue).
- Reset mid-handshake: assert rst while ack=1 with 5 bits captured → ack=0 next edge. After release, 8 new bits 8'h3C → word=8'h3C, frame_err never asserted.
